// File: rtl/idelayctrl_rst_seq.sv
// idelayctrl_rst_seq
//   Reset sequencer and lock monitor for an IDELAYCTRL on the same reference clock.
//   It drives a fixed-width RST pulse and then waits for a filtered RDY. If RDY does not
//   arrive before the timeout, it retries a bounded number of times and then reports FAIL.
//   A loss of RDY while locked restarts the sequence and is counted.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_HOLD    | ctrl_rst high, counting out RST_CYCLES
//   ST_WAIT    | ctrl_rst low, filtering rdy_s, timing out after RDY_TIMEOUT
//   ST_LOCKED  | RDY confirmed; any low rdy_s is a loss event
//   ST_FAIL    | all retries used without lock; parked until start or reset

module idelayctrl_rst_seq #(
    parameter int RST_CYCLES  = 16,
    parameter int RDY_TIMEOUT = 1024,
    parameter int RDY_FILTER  = 4,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic       refclk_in,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rdy_in,
    output logic       ctrl_rst,
    output logic       locked,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int                FILT_W    = $clog2(RDY_FILTER) + 1;
    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(RDY_FILTER - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cyc_cnt;
    logic [FILT_W-1:0]   filt_cnt;
    logic                rdy_meta;
    logic                rdy_s;
    logic                loss_evt;

    // A loss is seen in LOCKED whenever the synchronized RDY is low, even when
    // start arrives on the same edge.
    assign loss_evt = (state == ST_LOCKED) && !rdy_s;

    // Two-flop synchronizer: RDY comes from the IDELAYCTRL with no timing relationship.
    always_ff @(posedge refclk_in or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= rdy_in;
            rdy_s    <= rdy_meta;
        end
    end

    // Sequencing FSM. Outputs are set on the same edge as the state change so
    // that they are registered and never glitch.
    always_ff @(posedge refclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HOLD;
            cyc_cnt   <= '0;
            filt_cnt  <= '0;
            ctrl_rst  <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (loss_evt && loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end

            if (start) begin
                state     <= ST_HOLD;
                cyc_cnt   <= '0;
                filt_cnt  <= '0;
                retry_cnt <= '0;
                ctrl_rst  <= 1'b1;
                locked    <= 1'b0;
                fail      <= 1'b0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        ctrl_rst <= 1'b1;
                        filt_cnt <= '0;
                        if (cyc_cnt == RST_LAST) begin
                            state    <= ST_WAIT;
                            cyc_cnt  <= '0;
                            ctrl_rst <= 1'b0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end

                    ST_WAIT: begin
                        cyc_cnt  <= cyc_cnt + CNT_W'(1);
                        filt_cnt <= rdy_s ? filt_cnt + FILT_W'(1) : '0;
                        // Lock is checked first so it wins over a coincident timeout.
                        if (rdy_s && filt_cnt == FILT_LAST) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            cyc_cnt  <= '0;
                            filt_cnt <= '0;
                        end else if (cyc_cnt == TMO_LAST) begin
                            cyc_cnt <= '0;
                            if (int'(retry_cnt) < MAX_RETRY) begin
                                if (retry_cnt != 8'hFF) begin
                                    retry_cnt <= retry_cnt + 8'd1;
                                end
                                state    <= ST_HOLD;
                                ctrl_rst <= 1'b1;
                            end else begin
                                state <= ST_FAIL;
                                fail  <= 1'b1;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        if (!rdy_s) begin
                            state     <= ST_HOLD;
                            locked    <= 1'b0;
                            ctrl_rst  <= 1'b1;
                            retry_cnt <= '0;
                            cyc_cnt   <= '0;
                        end
                    end

                    ST_FAIL: begin
                        fail <= 1'b1;
                    end

                    default: begin
                        state    <= ST_HOLD;
                        cyc_cnt  <= '0;
                        ctrl_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_idelayctrl_rst_seq.sv
// tb_idelayctrl_rst_seq
//   Directed vector table, hand-written retry/fail/saturation sequences and a
//   randomized run, all checked against a phase-level reference model.

module tb_idelayctrl_rst_seq;

    localparam int RST_CYCLES  = 16;
    localparam int RDY_TIMEOUT = 1024;
    localparam int RDY_FILTER  = 4;
    localparam int MAX_RETRY   = 3;

    logic       refclk_in = 1'b0;
    logic       rst_n     = 1'b1;
    logic       start     = 1'b0;
    logic       rdy_in    = 1'b0;
    logic       ctrl_rst;
    logic       locked;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;

    idelayctrl_rst_seq #(
        .RST_CYCLES (RST_CYCLES),
        .RDY_TIMEOUT(RDY_TIMEOUT),
        .RDY_FILTER (RDY_FILTER),
        .MAX_RETRY  (MAX_RETRY),
        .CNT_W      (16)
    ) dut (
        .refclk_in(refclk_in),
        .rst_n    (rst_n),
        .start    (start),
        .rdy_in   (rdy_in),
        .ctrl_rst (ctrl_rst),
        .locked   (locked),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk_in = ~refclk_in;

    // Reference model: which phase we are in, how long we have been there,
    // and how many trailing synchronized-high samples have been seen.
    localparam int P_HOLD = 0;
    localparam int P_WAIT = 1;
    localparam int P_LOCK = 2;
    localparam int P_FAIL = 3;

    int m_phase;
    int m_elapsed;
    int m_run;
    int m_retry;
    int m_loss;
    bit m_pipe[$];

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic m_reset();
        m_phase   = P_HOLD;
        m_elapsed = 0;
        m_run     = 0;
        m_retry   = 0;
        m_loss    = 0;
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
    endtask

    task automatic m_step(input bit st, input bit rdy);
        bit rs;
        rs = m_pipe.pop_front();
        m_pipe.push_back(rdy);
        if (st) begin
            if (m_phase == P_LOCK && !rs) m_loss = sat255(m_loss + 1);
            m_phase   = P_HOLD;
            m_elapsed = 0;
            m_retry   = 0;
        end else begin
            case (m_phase)
                P_HOLD: begin
                    m_elapsed++;
                    if (m_elapsed == RST_CYCLES) begin
                        m_phase   = P_WAIT;
                        m_elapsed = 0;
                        m_run     = 0;
                    end
                end
                P_WAIT: begin
                    m_elapsed++;
                    m_run = rs ? m_run + 1 : 0;
                    if (m_run >= RDY_FILTER) begin
                        m_phase = P_LOCK;
                    end else if (m_elapsed >= RDY_TIMEOUT) begin
                        m_elapsed = 0;
                        if (m_retry < MAX_RETRY) begin
                            m_retry++;
                            m_phase = P_HOLD;
                        end else begin
                            m_phase = P_FAIL;
                        end
                    end
                end
                P_LOCK: begin
                    if (!rs) begin
                        m_loss    = sat255(m_loss + 1);
                        m_retry   = 0;
                        m_phase   = P_HOLD;
                        m_elapsed = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge refclk_in);
        if (rst_n) m_step(start, rdy_in);
        @(negedge refclk_in);
    endtask

    task automatic check_exp(input string name, input bit e_rst, input bit e_lock,
                             input bit e_fail, input int e_retry, input int e_loss);
        total++;
        if (ctrl_rst !== e_rst || locked !== e_lock || fail !== e_fail ||
            retry_cnt !== 8'(e_retry) || loss_cnt !== 8'(e_loss)) begin
            bad++;
            $display("FAIL %s: got rst=%b lock=%b fail=%b retry=%0d loss=%0d, want rst=%b lock=%b fail=%b retry=%0d loss=%0d",
                     name, ctrl_rst, locked, fail, retry_cnt, loss_cnt,
                     e_rst, e_lock, e_fail, e_retry, e_loss);
        end
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_phase == P_HOLD, m_phase == P_LOCK, m_phase == P_FAIL, m_retry, m_loss);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic apply_reset();
        start  = 1'b0;
        rdy_in = 1'b0;
        rst_n  = 1'b0;
        m_reset();
        #1;
        check_exp("reset", 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic async_reset_pulse(input string name);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_exp(name, 1'b1, 1'b0, 1'b0, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_locked(input int budget, input string name);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!locked) begin
            bad++;
            $display("FAIL %s: locked=%b after %0d cycles, want 1", name, locked, n);
        end
    endtask

    typedef struct {
        string name;
        bit    st;
        bit    rdy;
        int    cyc;
        bit    e_rst;
        bit    e_lock;
        bit    e_fail;
        int    e_retry;
        int    e_loss;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int widths[$];
        int gaps[$];
        int hi, lo, n, hold_left;
        bit prev;

        // Timing is counted from reset release; rdy rises after 20 edges.
        vecs.push_back('{"hold_15",     1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"hold_end",    1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"wait_pre",    1'b0, 1'b0,  4, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"rdy_5",       1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"lock_6",      1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{"dip_edge1",   1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{"dip_edge2",   1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{"loss_edge3",  1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"rehold_15",   1'b0, 1'b1, 15, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"rehold_end",  1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"refilter_3",  1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"relock",      1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 1});
        vecs.push_back('{"start_lock",  1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"st_hold_15",  1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"st_hold_end", 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"glitch_3hi",  1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"glitch_lo",   1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"rdy_again_5", 1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{"lock_after4", 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 1});

        #2;
        apply_reset();
        check_exp("release", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            start  = vecs[i].st;
            rdy_in = vecs[i].rdy;
            repeat (vecs[i].cyc) tick();
            check_exp(vecs[i].name, vecs[i].e_rst, vecs[i].e_lock, vecs[i].e_fail,
                      vecs[i].e_retry, vecs[i].e_loss);
            check_model({vecs[i].name, "_model"});
        end
        start = 1'b0;

        // RDY stuck low: four RST pulses, three timeout gaps, then FAIL.
        apply_reset();
        hi   = 1;
        lo   = 0;
        prev = 1'b1;
        for (int c = 0; c < 5000 && !fail; c++) begin
            tick();
            if (ctrl_rst) begin
                if (!prev) begin
                    gaps.push_back(lo);
                    lo = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    widths.push_back(hi);
                    hi = 0;
                end
                lo++;
            end
            prev = ctrl_rst;
        end
        check_int("pulse_count", widths.size(), 4);
        foreach (widths[k]) check_int("pulse_width", widths[k], RST_CYCLES);
        check_int("gap_count", gaps.size(), 3);
        foreach (gaps[k]) check_int("gap_width", gaps[k], RDY_TIMEOUT);
        check_exp("fail_state", 1'b0, 1'b0, 1'b1, 3, 0);
        check_model("fail_state_model");
        repeat (5) tick();
        check_exp("fail_parked", 1'b0, 1'b0, 1'b1, 3, 0);

        // start clears FAIL and gives a fresh full-width pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_exp("start_in_fail", 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (15) tick();
        check_exp("fail_restart_hi", 1'b1, 1'b0, 1'b0, 0, 0);
        tick();
        check_exp("fail_restart_lo", 1'b0, 1'b0, 1'b0, 0, 0);

        // start held high keeps the counter parked at zero.
        start = 1'b1;
        repeat (20) tick();
        check_exp("start_held", 1'b1, 1'b0, 1'b0, 0, 0);
        start = 1'b0;
        repeat (15) tick();
        check_exp("after_held_hi", 1'b1, 1'b0, 1'b0, 0, 0);
        tick();
        check_exp("after_held_lo", 1'b0, 1'b0, 1'b0, 0, 0);

        // 300 loss events: the counter sticks at 255.
        apply_reset();
        rdy_in = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            wait_locked(40, "loss_relock");
            rdy_in = 1'b0;
            tick();
            rdy_in = 1'b1;
            n = 0;
            while (locked && n < 5) begin
                tick();
                n++;
            end
            check_int("loss_cnt", int'(loss_cnt), sat255(i));
        end
        check_model("loss_sat_model");

        // Then RDY stuck low until the third attempt's WAIT, and reset mid-WAIT.
        rdy_in = 1'b0;
        n = 0;
        while (!(m_phase == P_WAIT && m_retry == 2 && m_elapsed == 100) && n < 4000) begin
            tick();
            n++;
        end
        check_exp("mid_wait_retry2", 1'b0, 1'b0, 1'b0, 2, 255);
        check_model("mid_wait_model");
        async_reset_pulse("async_rst_mid_wait");

        // Randomized run against the model.
        apply_reset();
        hold_left = 0;
        for (int c = 0; c < 6000 && bad < 40; c++) begin
            if (hold_left == 0) begin
                rdy_in    = ~rdy_in;
                hold_left = rdy_in ? $urandom_range(1, 80) : $urandom_range(1, 8);
            end
            hold_left--;
            start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1999) == 0) begin
                async_reset_pulse("rand_async_rst");
            end else begin
                tick();
                check_model("rand");
            end
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
